// File: rtl/l2_port_arbiter_pkg.sv
// Shared types and line-geometry constants for the L2 port arbiter.
package l2_port_arbiter_pkg;

    localparam int L2_LINE_ADDR_W = 12;   // ADR[15:4], 16-byte lines
    localparam int L2_LINE_W      = 128;  // one cache line

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT0,
        ARB_GNT1,
        ARB_TURN
    } l2_arb_state_t;

endpackage

// File: rtl/l2_port_arbiter_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    assign o_cnt = r_cnt;

    // Clear first, then increment unless already at all-ones
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin Wishbone arbiter sharing the L2 port between dcache (M0) and
// icache (M1). The grant is registered and held for a whole transaction,
// followed by one dead cycle so the winner can drop STB after its ACK.
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = L2_LINE_ADDR_W,
    parameter int DATA_W = L2_LINE_W,
    parameter int SEL_W  = DATA_W / 8,
    parameter int CNT_W  = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [1:0]          m_cyc,
    input  logic [1:0]          m_stb,
    input  logic [1:0]          m_we,
    input  logic [2*SEL_W-1:0]  m_sel,
    input  logic [2*ADDR_W-1:0] m_adr,
    input  logic [2*DATA_W-1:0] m_dat_w,
    output logic [DATA_W-1:0]   m_dat_r,
    output logic [1:0]          m_ack,
    output logic [1:0]          m_rty,
    output logic                s_cyc,
    output logic                s_stb,
    output logic                s_we,
    output logic [SEL_W-1:0]    s_sel,
    output logic [ADDR_W-1:0]   s_adr,
    output logic [DATA_W-1:0]   s_dat_w,
    input  logic [DATA_W-1:0]   s_dat_r,
    input  logic                s_ack,
    input  logic                s_rty,
    output logic [2*CNT_W-1:0]  grant_cnt,
    output logic [2*CNT_W-1:0]  wait_cnt,
    input  logic [1:0]          cnt_clear
);

    l2_arb_state_t r_state;
    l2_arb_state_t w_state_nxt;
    logic          r_last;       // master served most recently; the other wins a tie
    logic          w_last_nxt;
    logic [1:0]    w_req;
    logic          w_gnt_idx;
    logic [1:0]    w_gnt_inc;
    logic [1:0]    w_wait_inc;

    assign w_req     = m_cyc & m_stb;
    assign w_gnt_idx = (r_state == ARB_GNT1);
    assign m_dat_r   = s_dat_r;

    // Only a real ACK while granted counts; RTY and stray ACKs do not
    assign w_gnt_inc[0]  = (r_state == ARB_GNT0) & s_ack;
    assign w_gnt_inc[1]  = (r_state == ARB_GNT1) & s_ack;
    assign w_wait_inc[0] = w_req[0] & (r_state != ARB_GNT0);
    assign w_wait_inc[1] = w_req[1] & (r_state != ARB_GNT1);

    // State register; reset favours M0 on the first tie
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state selection and slave/master output mux
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        s_cyc       = 1'b0;
        s_stb       = 1'b0;
        s_we        = 1'b0;
        s_sel       = '0;
        s_adr       = '0;
        s_dat_w     = '0;
        m_ack       = 2'b00;
        m_rty       = 2'b00;

        case (r_state)
            ARB_IDLE: begin
                if (w_req == 2'b11) begin
                    w_state_nxt = r_last ? ARB_GNT0 : ARB_GNT1;
                end else if (w_req[0]) begin
                    w_state_nxt = ARB_GNT0;
                end else if (w_req[1]) begin
                    w_state_nxt = ARB_GNT1;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                s_cyc   = m_cyc[w_gnt_idx];
                s_stb   = m_stb[w_gnt_idx] & m_cyc[w_gnt_idx];
                s_we    = m_we[w_gnt_idx];
                s_sel   = w_gnt_idx ? m_sel[2*SEL_W-1:SEL_W]     : m_sel[SEL_W-1:0];
                s_adr   = w_gnt_idx ? m_adr[2*ADDR_W-1:ADDR_W]   : m_adr[ADDR_W-1:0];
                s_dat_w = w_gnt_idx ? m_dat_w[2*DATA_W-1:DATA_W] : m_dat_w[DATA_W-1:0];
                m_ack[w_gnt_idx] = s_ack;
                m_rty[w_gnt_idx] = s_rty;
                // An abort releases the port without touching fairness state
                if (!m_cyc[w_gnt_idx]) begin
                    w_state_nxt = ARB_IDLE;
                end else if (s_ack || s_rty) begin
                    w_state_nxt = ARB_TURN;
                    w_last_nxt  = w_gnt_idx;
                end
            end
            ARB_TURN: begin
                w_state_nxt = ARB_IDLE;
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_grant (
            .i_clk (CLK),
            .i_rst (RST),
            .i_inc (w_gnt_inc[gi]),
            .i_clr (cnt_clear[gi]),
            .o_cnt (grant_cnt[gi*CNT_W +: CNT_W])
        );
        sat_counter #(.CNT_W(CNT_W)) u_wait (
            .i_clk (CLK),
            .i_rst (RST),
            .i_inc (w_wait_inc[gi]),
            .i_clr (cnt_clear[gi]),
            .o_cnt (wait_cnt[gi*CNT_W +: CNT_W])
        );
    end

endmodule
